fifo_ctrl_sync: RTL and testbench

Pointer and flag controller for the single-clock FIFO. It sits directly upstream of the synchronous FIFO memory and turns raw push/pop requests into accepted `wen`/`ren` strobes, write/read addresses, an occupancy count, status flags and error indications. It has no data path: data travels straight from producer to memory. `rvalid` marks the cycle in which the memory's registered `rdata` is valid.

---
 rtl/fifo_ctrl_sync.sv | 130 +++++++++++++
 tb/tb_fifo_ctrl_sync.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_sync.sv
// Pointer/flag controller for a single-clock FIFO; optional sticky errors via FIFO_CTRL_STICKY_ERR_EN.
// Latency: wen/ren/waddr/raddr same cycle; count/flags/rvalid/errors one cycle after the accepting edge.
// Backpressure: writes are refused while full and reads while empty; refused requests raise overflow/underflow.
module fifo_ctrl_sync #(
    parameter int ASIZE     = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_req,
    input  logic             rd_req,
    input  logic             clr_err,
    output logic             wen,
    output logic             ren,
    output logic [ASIZE-1:0] waddr,
    output logic [ASIZE-1:0] raddr,
    output logic             rvalid,
    output logic [ASIZE:0]   count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [ASIZE:0] C_DEPTH  = (ASIZE+1)'(1 << ASIZE);
    localparam logic [ASIZE:0] C_AFULL  = (ASIZE+1)'(AFULL_TH);
    localparam logic [ASIZE:0] C_AEMPTY = (ASIZE+1)'(AEMPTY_TH);
    localparam logic [ASIZE:0] C_ONE    = (ASIZE+1)'(1);

    logic [ASIZE:0] r_wptr;
    logic [ASIZE:0] r_rptr;
    logic [ASIZE:0] r_count;
    logic           r_full;
    logic           r_empty;
    logic           r_afull;
    logic           r_aempty;
    logic           r_rvalid;
    logic           r_ovf;
    logic           r_udf;

    logic           w_wen;
    logic           w_ren;
    logic           w_ovf_evt;
    logic           w_udf_evt;
    logic [ASIZE:0] w_count_nxt;

    assign w_wen     = wr_req & ~r_full;
    assign w_ren     = rd_req & ~r_empty;
    assign w_ovf_evt = wr_req & r_full;
    assign w_udf_evt = rd_req & r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wen && !w_ren) begin
            w_count_nxt = r_count + C_ONE;
        end else if (!w_wen && w_ren) begin
            w_count_nxt = r_count - C_ONE;
        end
    end

    // Flags are computed from the next count so they are registered alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_rvalid <= 1'b0;
        end else begin
            if (w_wen) begin
                r_wptr <= r_wptr + C_ONE;
            end
            if (w_ren) begin
                r_rptr <= r_rptr + C_ONE;
            end
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == C_DEPTH);
            r_empty  <= (w_count_nxt == '0);
            r_afull  <= (w_count_nxt >= C_AFULL);
            r_aempty <= (w_count_nxt <= C_AEMPTY);
            r_rvalid <= w_ren;
        end
    end

`ifdef FIFO_CTRL_STICKY_ERR_EN
    // A new event outranks a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_evt | (r_ovf & ~clr_err);
            r_udf <= w_udf_evt | (r_udf & ~clr_err);
        end
    end
`else
    logic w_unused_clr;
    assign w_unused_clr = clr_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_evt;
            r_udf <= w_udf_evt;
        end
    end
`endif

    assign wen          = w_wen;
    assign ren          = w_ren;
    assign waddr        = r_wptr[ASIZE-1:0];
    assign raddr        = r_rptr[ASIZE-1:0];
    assign rvalid       = r_rvalid;
    assign count        = r_count;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule

// File: tb/tb_fifo_ctrl_sync.sv
// Directed bench for fifo_ctrl_sync with a behavioural occupancy model and a read-address scoreboard.
module tb_fifo_ctrl_sync;

    logic       clk;
    logic       rst_n;
    logic       wr_req;
    logic       rd_req;
    logic       clr_err;
    logic       wen;
    logic       ren;
    logic [3:0] waddr;
    logic [3:0] raddr;
    logic       rvalid;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    int n_cmp = 0;
    int n_err = 0;

    int         m_count;
    logic [4:0] m_wptr;
    logic [4:0] m_rptr;
    logic       m_rvalid;
    logic       m_ovf;
    logic       m_udf;
    logic [3:0] sb[$];

    fifo_ctrl_sync #(.ASIZE(4), .AFULL_TH(12), .AEMPTY_TH(4)) dut (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .rd_req(rd_req), .clr_err(clr_err),
        .wen(wen), .ren(ren), .waddr(waddr), .raddr(raddr), .rvalid(rvalid),
        .count(count), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count  = 0;
        m_wptr   = '0;
        m_rptr   = '0;
        m_rvalid = 1'b0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        sb.delete();
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_count"}, count, m_count);
        chk({tag, "_full"}, full, m_count == 16);
        chk({tag, "_empty"}, empty, m_count == 0);
        chk({tag, "_afull"}, almost_full, m_count >= 12);
        chk({tag, "_aempty"}, almost_empty, m_count <= 4);
        chk({tag, "_rvalid"}, rvalid, m_rvalid);
        chk({tag, "_ovf"}, overflow, m_ovf);
        chk({tag, "_udf"}, underflow, m_udf);
    endtask

    task automatic step(input logic wr, input logic rd, input logic clr);
        logic       e_wen;
        logic       e_ren;
        logic       ovf_evt;
        logic       udf_evt;
        logic [3:0] obs_raddr;
        @(negedge clk);
        wr_req  = wr;
        rd_req  = rd;
        clr_err = clr;
        #1;
        e_wen   = wr && (m_count != 16);
        e_ren   = rd && (m_count != 0);
        ovf_evt = wr && (m_count == 16);
        udf_evt = rd && (m_count == 0);
        chk("wen", wen, e_wen);
        chk("ren", ren, e_ren);
        if (e_wen) begin
            chk("waddr", waddr, m_wptr[3:0]);
            sb.push_back(m_wptr[3:0]);
        end
        if (e_ren) chk("raddr", raddr, m_rptr[3:0]);
        obs_raddr = raddr;
        @(posedge clk);
        #1;
        if (e_wen) m_wptr = m_wptr + 5'd1;
        if (e_ren) m_rptr = m_rptr + 5'd1;
        if (e_wen && !e_ren) m_count++;
        else if (!e_wen && e_ren) m_count--;
        m_rvalid = e_ren;
`ifdef FIFO_CTRL_STICKY_ERR_EN
        m_ovf = ovf_evt | (m_ovf & ~clr);
        m_udf = udf_evt | (m_udf & ~clr);
`else
        m_ovf = ovf_evt;
        m_udf = udf_evt;
`endif
        check_regs("step");
        if (rvalid) begin
            if (sb.size() > 0) chk("sb_raddr", obs_raddr, sb.pop_front());
            else chk("sb_unexpected_rvalid", rvalid, 1'b0);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        clr_err = 1'b0;
        model_reset();
        #23;
        check_regs("reset");
        chk("reset_wen", wen, 1'b0);
        chk("reset_ren", ren, 1'b0);
        chk("reset_waddr", waddr, 4'd0);
        chk("reset_raddr", raddr, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;

        step(0, 0, 0);
        step(1, 0, 0);

        // fill to 16, then an overflowing 17th write and clear handling
        for (int i = 1; i < 16; i++) step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        step(1, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0);

        // drain 16, then an underflowing 17th read
        for (int i = 0; i < 16; i++) step(0, 1, 0);
        step(0, 1, 0);
        step(0, 0, 1);
        step(0, 0, 0);

        // wrap-around passes
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 10; i++) step(1, 0, 0);
            for (int i = 0; i < 10; i++) step(0, 1, 0);
        end

        // simultaneous requests at full, empty and mid occupancy
        for (int i = 0; i < 16; i++) step(1, 0, 0);
        step(1, 1, 0);
        for (int i = 0; i < 15; i++) step(0, 1, 0);
        step(1, 1, 0);
        for (int i = 1; i < 7; i++) step(1, 0, 0);
        step(1, 1, 0);
        step(1, 1, 0);

        // asynchronous reset at count 9 mid-burst
        step(1, 0, 0);
        step(1, 0, 0);
        @(negedge clk);
        wr_req = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        wr_req = 1'b0;
        model_reset();
        #1;
        check_regs("async_rst");
        chk("async_rst_wen", wen, 1'b0);
        chk("async_rst_waddr", waddr, 4'd0);
        chk("async_rst_raddr", raddr, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
